// File: rtl/serial_paralelo_if.sv
// serial_paralelo_if: serial bit input plus recovered byte, valid and link status
interface serial_paralelo_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  modport master(output data_in, input data_out, valid_out, active);
  modport slave(input data_in, output data_out, valid_out, active);
endinterface

// File: rtl/serial_paralelo.sv
// serial_paralelo: comma-aligned serial-to-parallel byte receiver, MSB first, one bit per clk_32f
module serial_paralelo #(
  parameter logic [7:0] COMMA   = 8'hBC,
  parameter int         N_COMMA = 4
) (
  input logic              clk_32f,
  input logic              reset,
  serial_paralelo_if.slave bus
);
  typedef enum logic [1:0] {HUNT, SYNC, ACTIVE} state_t;
  localparam logic [3:0] N = 4'(N_COMMA);
  state_t     state_q, state_d;
  logic [6:0] sr_q, sr_d;
  logic [7:0] data_q, data_d, w;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;
  logic       valid_q, valid_d, active_q, active_d, bnd, is_c;
  assign w    = {sr_q, bus.data_in};
  assign bnd  = bit_cnt_q == 3'd7;
  assign is_c = w == COMMA;
  always_comb begin
    state_d   = state_q;
    sr_d      = w[6:0];
    data_d    = data_q;
    bit_cnt_d = bit_cnt_q + 3'd1;
    bc_cnt_d  = bc_cnt_q;
    valid_d   = valid_q;
    active_d  = active_q;
    case (state_q)
      HUNT: begin
        bit_cnt_d = is_c ? 3'd0 : bit_cnt_q;
        bc_cnt_d  = is_c ? 4'd1 : bc_cnt_q;
        state_d   = !is_c ? HUNT : (N == 4'd1) ? ACTIVE : SYNC;
        active_d  = is_c && N == 4'd1;
      end
      SYNC: begin
        if (bnd) begin
          bc_cnt_d = is_c ? bc_cnt_q + 4'd1 : 4'd0;
          state_d  = !is_c ? HUNT : (bc_cnt_q + 4'd1 == N) ? ACTIVE : SYNC;
          active_d = is_c && bc_cnt_q + 4'd1 == N;
        end
      end
      ACTIVE: begin
        data_d  = (bnd && !is_c) ? w : data_q;
        valid_d = bnd ? !is_c : valid_q;
      end
      default: state_d = HUNT;
    endcase
  end
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q   <= HUNT;
      sr_q      <= '0;
      data_q    <= '0;
      bit_cnt_q <= '0;
      bc_cnt_q  <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      data_q    <= data_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
    end
  end
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.active    = active_q;
endmodule

// File: tb/tb_serial_paralelo.sv
// tb_serial_paralelo: table-driven scoreboard bench for serial_paralelo
module tb_serial_paralelo;
  logic clk_32f = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_32f = ~clk_32f;
  serial_paralelo_if bus();
  serial_paralelo #(.COMMA(8'hBC), .N_COMMA(4)) dut (
    .clk_32f(clk_32f),
    .reset(reset),
    .bus(bus.slave)
  );
  typedef struct {
    logic [7:0] din;
    logic [7:0] data;
    logic       valid;
    logic       act;
  } vec_t;
  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       act;
  } exp_t;
  localparam exp_t ZERO = '{8'h00, 1'b0, 1'b0};
  exp_t exp_q[$];
  exp_t hold;
  int   checks   = 0;
  int   failures = 0;
  vec_t lock_t[4];
  vec_t data_t[8];
  vec_t brk_t[7];
  vec_t strad_t[9];
  task automatic check(input string name, input exp_t e);
    checks++;
    if (bus.data_out !== e.data || bus.valid_out !== e.valid || bus.active !== e.act) begin
      failures++;
      $display("FAIL %s: got data=%h valid=%b active=%b, want data=%h valid=%b active=%b",
               name, bus.data_out, bus.valid_out, bus.active, e.data, e.valid, e.act);
    end
  endtask
  task automatic tick(input logic b);
    bus.data_in = b;
    @(posedge clk_32f);
    #1;
  endtask
  task automatic send_byte(input vec_t v, input string name);
    exp_q.push_back('{v.data, v.valid, v.act});
    for (int i = 7; i >= 0; i--) begin
      tick(v.din[i]);
      if (i > 0) check({name, "_hold"}, hold);
    end
    hold = exp_q.pop_front();
    check(name, hold);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'($urandom));
      check("reset", ZERO);
    end
    reset = 1'b0;
    hold  = ZERO;
  endtask
  initial begin
    bus.data_in = 1'b0;
    lock_t  = '{'{8'hBC, 8'h00, 1'b0, 1'b0}, '{8'hBC, 8'h00, 1'b0, 1'b0},
                '{8'hBC, 8'h00, 1'b0, 1'b0}, '{8'hBC, 8'h00, 1'b0, 1'b1}};
    data_t  = '{'{8'hBC, 8'h00, 1'b0, 1'b0}, '{8'hBC, 8'h00, 1'b0, 1'b0},
                '{8'hBC, 8'h00, 1'b0, 1'b0}, '{8'hBC, 8'h00, 1'b0, 1'b1},
                '{8'h9D, 8'h9D, 1'b1, 1'b1}, '{8'hFF, 8'hFF, 1'b1, 1'b1},
                '{8'hEE, 8'hEE, 1'b1, 1'b1}, '{8'hBC, 8'hEE, 1'b0, 1'b1}};
    brk_t   = '{'{8'hBC, 8'h00, 1'b0, 1'b0}, '{8'hBC, 8'h00, 1'b0, 1'b0},
                '{8'h00, 8'h00, 1'b0, 1'b0}, '{8'hBC, 8'h00, 1'b0, 1'b0},
                '{8'hBC, 8'h00, 1'b0, 1'b0}, '{8'hBC, 8'h00, 1'b0, 1'b0},
                '{8'hBC, 8'h00, 1'b0, 1'b1}};
    strad_t = '{'{8'hBC, 8'h00, 1'b0, 1'b0}, '{8'hBC, 8'h00, 1'b0, 1'b0},
                '{8'hBC, 8'h00, 1'b0, 1'b0}, '{8'hBC, 8'h00, 1'b0, 1'b1},
                '{8'h0B, 8'h0B, 1'b1, 1'b1}, '{8'hC0, 8'hC0, 1'b1, 1'b1},
                '{8'h17, 8'h17, 1'b1, 1'b1}, '{8'h80, 8'h80, 1'b1, 1'b1},
                '{8'hBC, 8'h80, 1'b0, 1'b1}};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick(1'b0);
      check("idle_zeros", ZERO);
    end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'($urandom));
      check("misalign", ZERO);
    end
    foreach (lock_t[i]) send_byte(lock_t[i], $sformatf("lock%0d", i));
    do_reset();
    foreach (data_t[i]) send_byte(data_t[i], $sformatf("data%0d", i));
    send_byte('{8'hBC, 8'hEE, 1'b0, 1'b1}, "data_keep");
    do_reset();
    foreach (brk_t[i]) send_byte(brk_t[i], $sformatf("broken%0d", i));
    do_reset();
    foreach (strad_t[i]) send_byte(strad_t[i], $sformatf("straddle%0d", i));
    do_reset();
    foreach (lock_t[i]) send_byte(lock_t[i], $sformatf("relock_pre%0d", i));
    send_byte('{8'h5A, 8'h5A, 1'b1, 1'b1}, "mid_data");
    for (int i = 7; i > 4; i--) begin
      tick(1'(8'hA5 >> i));
      check("mid_bits", hold);
    end
    reset = 1'b1;
    tick(1'b0);
    reset = 1'b0;
    check("mid_reset", ZERO);
    hold = ZERO;
    foreach (lock_t[i]) send_byte(lock_t[i], $sformatf("relock%0d", i));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
